// File: rtl/bt_pkg.sv
// bt_pkg: traceback codes and saturating arithmetic shared by the select pipeline
package bt_pkg;
  localparam logic [1:0] BT_MATCH = 2'd0;
  localparam logic [1:0] BT_E     = 2'd1;
  localparam logic [1:0] BT_F     = 2'd2;
  localparam logic [1:0] BT_ZERO  = 2'd3;
  function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a, input logic signed [31:0] b, input int w);
    return sat(a + b, w);
  endfunction
  function automatic logic signed [31:0] sat_sub(input logic signed [31:0] a, input logic signed [31:0] b, input int w);
    return sat(a - b, w);
  endfunction
endpackage

// File: rtl/bt_lane.sv
// bt_lane: one cell of max(M,E,F) selection with gap updates and traceback code
module bt_lane
  import bt_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BT_WIDTH   = 8,
  parameter int GAP_O      = 4,
  parameter int GAP_E      = 2
) (
  input  logic                         i_local_mode,
  input  logic signed [DATA_WIDTH-1:0] i_m,
  input  logic signed [DATA_WIDTH-1:0] i_e,
  input  logic signed [DATA_WIDTH-1:0] i_f,
  output logic signed [DATA_WIDTH-1:0] o_h,
  output logic signed [DATA_WIDTH-1:0] o_e_next,
  output logic signed [DATA_WIDTH-1:0] o_f_next,
  output logic        [BT_WIDTH-1:0]   o_d
);
  logic [1:0] w_code;
  logic w_zero;
  logic signed [DATA_WIDTH-1:0] w_mx;
  logic signed [31:0] w_hg, w_eg, w_fg;
  always_comb begin
    w_code   = (i_m > i_e && i_m > i_f) ? BT_MATCH : (i_e >= i_f) ? BT_E : BT_F;
    w_mx     = w_code == BT_MATCH ? i_m : w_code == BT_E ? i_e : i_f;
    w_zero   = i_local_mode && w_mx < 0;
    o_h      = w_zero ? '0 : w_mx;
    w_hg     = sat_sub(32'(o_h), GAP_O + GAP_E, DATA_WIDTH);
    w_eg     = sat_sub(32'(i_e), GAP_E, DATA_WIDTH);
    w_fg     = sat_sub(32'(i_f), GAP_E, DATA_WIDTH);
    o_e_next = DATA_WIDTH'(w_eg > w_hg ? w_eg : w_hg);
    o_f_next = DATA_WIDTH'(w_fg > w_hg ? w_fg : w_hg);
    o_d      = BT_WIDTH'({w_fg >= w_hg, w_eg >= w_hg, w_zero ? BT_ZERO : w_code});
  end
endmodule

// File: rtl/bt_select_pipe.sv
// bt_select_pipe: two-stage lane select pipeline with per-row maximum tracking
module bt_select_pipe
  import bt_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BT_WIDTH   = 8,
  parameter int LANES      = 4,
  parameter int GAP_O      = 4,
  parameter int GAP_E      = 2,
  parameter int COL_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          local_mode,
  input  logic                          row_start,
  input  logic                          row_end,
  input  logic [LANES*DATA_WIDTH-1:0]   M,
  input  logic [LANES*DATA_WIDTH-1:0]   E,
  input  logic [LANES*DATA_WIDTH-1:0]   F,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]   H,
  output logic [LANES*DATA_WIDTH-1:0]   E_next,
  output logic [LANES*DATA_WIDTH-1:0]   F_next,
  output logic [LANES*BT_WIDTH-1:0]     D,
  output logic                          max_valid,
  output logic [DATA_WIDTH-1:0]         max_score,
  output logic [COL_W-1:0]              max_col
);
  localparam int LW = LANES * DATA_WIDTH;
  localparam logic signed [DATA_WIDTH-1:0] NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  logic w_en, w_hs, w_first;
  logic r_s1_valid, r_s1_local, r_s1_start, r_s1_end, r_s2_start, r_s2_end, r_fresh;
  logic [LW-1:0] r_s1_m, r_s1_e, r_s1_f, w_h, w_e_nx, w_f_nx;
  logic [LANES*BT_WIDTH-1:0] w_d;
  logic [COL_W-1:0] r_col, r_run_col, w_base, w_bcol, w_rcol;
  logic signed [DATA_WIDTH-1:0] r_run, w_bmax, w_rmax;
  assign w_en     = ~out_valid | out_ready;
  assign w_hs     = out_valid & out_ready;
  assign in_ready = w_en & ~rst_n;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    bt_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .BT_WIDTH  (BT_WIDTH),
      .GAP_O     (GAP_O),
      .GAP_E     (GAP_E)
    ) u_lane (
      .i_local_mode(r_s1_local),
      .i_m         (r_s1_m[k*DATA_WIDTH +: DATA_WIDTH]),
      .i_e         (r_s1_e[k*DATA_WIDTH +: DATA_WIDTH]),
      .i_f         (r_s1_f[k*DATA_WIDTH +: DATA_WIDTH]),
      .o_h         (w_h[k*DATA_WIDTH +: DATA_WIDTH]),
      .o_e_next    (w_e_nx[k*DATA_WIDTH +: DATA_WIDTH]),
      .o_f_next    (w_f_nx[k*DATA_WIDTH +: DATA_WIDTH]),
      .o_d         (w_d[k*BT_WIDTH +: BT_WIDTH])
    );
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_local <= 1'b0;
      r_s1_start <= 1'b0;
      r_s1_end   <= 1'b0;
      r_s1_m     <= '0;
      r_s1_e     <= '0;
      r_s1_f     <= '0;
      out_valid  <= 1'b0;
      r_s2_start <= 1'b0;
      r_s2_end   <= 1'b0;
      H          <= '0;
      E_next     <= '0;
      F_next     <= '0;
      D          <= '1;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      r_s1_local <= local_mode;
      r_s1_start <= row_start;
      r_s1_end   <= row_end;
      r_s1_m     <= M;
      r_s1_e     <= E;
      r_s1_f     <= F;
      out_valid  <= r_s1_valid;
      r_s2_start <= r_s1_start;
      r_s2_end   <= r_s1_end;
      H          <= w_h;
      E_next     <= w_e_nx;
      F_next     <= w_f_nx;
      D          <= w_d;
    end
  end
  // r_fresh makes the first beat after reset open a row even without row_start
  always_comb begin
    w_first = r_s2_start | r_fresh;
    w_base  = w_first ? '0 : r_col;
    w_bmax  = H[DATA_WIDTH-1:0];
    w_bcol  = w_base;
    for (int k = 1; k < LANES; k++)
      if ($signed(H[k*DATA_WIDTH +: DATA_WIDTH]) > w_bmax) begin
        w_bmax = H[k*DATA_WIDTH +: DATA_WIDTH];
        w_bcol = w_base + COL_W'(k);
      end
    w_rmax = (w_first || w_bmax > r_run) ? w_bmax : r_run;
    w_rcol = (w_first || w_bmax > r_run) ? w_bcol : r_run_col;
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_col     <= '0;
      r_fresh   <= 1'b1;
      r_run     <= NEG;
      r_run_col <= '0;
      max_valid <= 1'b0;
      max_score <= NEG;
      max_col   <= '0;
    end else begin
      max_valid <= w_hs & r_s2_end;
      if (w_hs) begin
        r_col     <= w_base + COL_W'(LANES);
        r_fresh   <= 1'b0;
        r_run     <= w_rmax;
        r_run_col <= w_rcol;
        if (r_s2_end) begin
          max_score <= w_rmax;
          max_col   <= w_rcol;
        end
      end
    end
  end
endmodule

// File: tb/tb_bt_select_pipe.sv
// tb_bt_select_pipe: directed table-driven and sequence checks for bt_select_pipe
module tb_bt_select_pipe;
  localparam logic [15:0] N100 = -16'sd100;
  logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, local_mode = 1'b0, row_start = 1'b0, row_end = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, max_valid;
  logic [63:0] M = '0, E = '0, F = '0, H, E_next, F_next;
  logic [31:0] D;
  logic [15:0] max_score, max_col;
  int n_tests = 0, n_fail = 0;
  typedef struct {
    logic        lm;
    logic [15:0] m, e, f, h, en, fn;
    logic [7:0]  d;
  } vec_t;
  vec_t v[12];
  logic [63:0] exp_q[$];
  logic [63:0] rows[3];
  logic [63:0] prev_h;
  logic [31:0] prev_d;
  logic prev_stall;
  logic [3:0] pat;
  int nsent, nrecv, npulse;
  logic [15:0] p_score, p_col;
  always #5 clk = ~clk;
  bt_select_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .local_mode(local_mode), .row_start(row_start), .row_end(row_end),
    .M(M), .E(E), .F(F), .out_valid(out_valid), .out_ready(out_ready),
    .H(H), .E_next(E_next), .F_next(F_next), .D(D),
    .max_valid(max_valid), .max_score(max_score), .max_col(max_col)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [63:0] p4(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction
  function automatic logic [63:0] rep(input logic [15:0] a);
    return {4{a}};
  endfunction
  task automatic beat(input logic lm, input logic rs, input logic re, input logic [63:0] m);
    in_valid = 1'b1; local_mode = lm; row_start = rs; row_end = re;
    M = m; E = rep(N100); F = rep(N100);
  endtask
  task automatic idle;
    in_valid = 1'b0; row_start = 1'b0; row_end = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    v[0]  = '{1'b0, 16'd5, 16'd5, 16'd3, 16'd5, 16'd3, 16'd1, 8'h0D};
    v[1]  = '{1'b1, -16'sd3, -16'sd7, -16'sd2, 16'd0, -16'sd6, -16'sd4, 8'h0B};
    v[2]  = '{1'b1, 16'd0, -16'sd7, -16'sd2, 16'd0, -16'sd6, -16'sd4, 8'h08};
    v[3]  = '{1'b0, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 8'h0D};
    v[4]  = '{1'b0, 16'd10, 16'd2, 16'd8, 16'd10, 16'd4, 16'd6, 8'h08};
    v[5]  = '{1'b0, 16'd1, 16'd3, 16'd7, 16'd7, 16'd1, 16'd5, 8'h0E};
    v[6]  = '{1'b0, 16'h7FFF, 16'd0, 16'd0, 16'h7FFF, 16'd32761, 16'd32761, 8'h00};
    v[7]  = '{1'b0, 16'd3, 16'd4, 16'd4, 16'd4, 16'd2, 16'd2, 8'h0D};
    v[8]  = '{1'b1, -16'sd1, -16'sd1, -16'sd1, 16'd0, -16'sd3, -16'sd3, 8'h0F};
    v[9]  = '{1'b0, -16'sd1, -16'sd1, -16'sd1, -16'sd1, -16'sd3, -16'sd3, 8'h0D};
    v[10] = '{1'b0, 16'h8000, 16'h8001, 16'h8000, 16'h8001, 16'h8000, 16'h8000, 8'h0D};
    v[11] = '{1'b0, 16'd2, 16'h8000, 16'd5, 16'd5, -16'sd1, 16'd3, 8'h0A};
    // reset state
    tick; tick;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_H", H, 64'd0);
    chk("rst_D", 64'(D), 64'hFFFF_FFFF);
    chk("rst_max_valid", 64'(max_valid), 64'd0);
    chk("rst_max_score", 64'(max_score), 64'h8000);
    chk("rst_max_col", 64'(max_col), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    // table vectors, one beat at a time, checking 2-cycle latency
    for (int i = 0; i < 12; i++) begin
      M = rep(v[i].m); E = rep(v[i].e); F = rep(v[i].f);
      in_valid = 1'b1; local_mode = v[i].lm;
      tick;
      idle;
      chk($sformatf("v%0d_lat1", i), 64'(out_valid), 64'd0);
      tick;
      chk($sformatf("v%0d_lat2", i), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_H", i), H, rep(v[i].h));
      chk($sformatf("v%0d_Enext", i), E_next, rep(v[i].en));
      chk($sformatf("v%0d_Fnext", i), F_next, rep(v[i].fn));
      chk($sformatf("v%0d_D", i), 64'(D), 64'({4{v[i].d}}));
      tick;
    end
    // streaming with backpressure pattern 1,0,0,1
    pat = 4'b1001; nsent = 0; nrecv = 0; prev_stall = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (nsent < 6) beat(1'b0, 1'b0, 1'b0, rep(16'(200 + nsent)));
      else idle;
      out_ready = pat[c % 4];
      #1;
      if (out_valid && out_ready) begin
        nrecv++;
        if (exp_q.size() == 0) chk("stream_extra_beat", H, 64'd0 - 64'd1);
        else chk($sformatf("stream_beat%0d", nrecv), H, exp_q.pop_front());
      end
      if (out_valid && !out_ready) begin
        if (prev_stall) begin
          chk("stall_hold_H", H, prev_h);
          chk("stall_hold_D", 64'(D), 64'(prev_d));
        end
        prev_h = H; prev_d = D; prev_stall = 1'b1;
      end else prev_stall = 1'b0;
      if (in_valid && in_ready) begin
        exp_q.push_back(M);
        nsent++;
      end
      tick;
    end
    idle;
    out_ready = 1'b1;
    chk("stream_recv_count", 64'(nrecv), 64'd6);
    chk("stream_queue_empty", 64'(exp_q.size()), 64'd0);
    tick; tick;
    // three-beat row, tie kept at earliest column
    rows[0] = p4(16'd1, 16'd9, 16'd2, 16'd9);
    rows[1] = p4(16'd9, 16'd0, 16'd0, 16'd0);
    rows[2] = p4(16'd3, 16'd3, 16'd3, 16'd3);
    npulse = 0; p_score = '0; p_col = '0;
    for (int c = 0; c < 10; c++) begin
      if (c < 3) beat(1'b0, c == 0, c == 2, rows[c]);
      else idle;
      tick;
      if (max_valid) begin npulse++; p_score = max_score; p_col = max_col; end
    end
    chk("row3_pulses", 64'(npulse), 64'd1);
    chk("row3_score", 64'(p_score), 64'd9);
    chk("row3_col", 64'(p_col), 64'd1);
    chk("row3_hold_score", 64'(max_score), 64'd9);
    chk("row3_hold_col", 64'(max_col), 64'd1);
    // single-beat row, negative scores, lowest lane wins tie
    npulse = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 0) beat(1'b0, 1'b1, 1'b1, p4(-16'sd5, -16'sd3, -16'sd3, -16'sd9));
      else idle;
      tick;
      if (max_valid) begin npulse++; p_score = max_score; p_col = max_col; end
    end
    chk("row1_pulses", 64'(npulse), 64'd1);
    chk("row1_score", 64'(p_score), 64'hFFFD);
    chk("row1_col", 64'(p_col), 64'd1);
    // reset mid-row
    beat(1'b0, 1'b1, 1'b0, p4(16'd50, 16'd1, 16'd1, 16'd1));
    tick;
    beat(1'b0, 1'b0, 1'b0, p4(16'd60, 16'd1, 16'd1, 16'd1));
    tick;
    idle;
    rst_n = 1'b1;
    tick;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_D", 64'(D), 64'hFFFF_FFFF);
    chk("midrst_H", H, 64'd0);
    chk("midrst_max_valid", 64'(max_valid), 64'd0);
    chk("midrst_max_score", 64'(max_score), 64'h8000);
    rst_n = 1'b0;
    npulse = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) beat(1'b0, 1'b0, 1'b1, p4(16'd4, 16'd7, 16'd1, 16'd2));
      else idle;
      tick;
      if (max_valid) begin npulse++; p_score = max_score; p_col = max_col; end
    end
    chk("after_rst_pulses", 64'(npulse), 64'd1);
    chk("after_rst_score", 64'(p_score), 64'd7);
    chk("after_rst_col", 64'(p_col), 64'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
